// File: rtl/input_layer_pingpong_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_layer_pingpong_queue : threshold pixels into two ping-pong FWFT index queues
// Revision 1.0
// ---------------------------------------------------------------------------
module input_layer_pingpong_queue #(
  parameter int INPUT_LAYER_NODES = 784,
  parameter int PIXEL_WIDTH       = 8,
  parameter int INDEX_WIDTH       = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputsInbound,
  input  logic [PIXEL_WIDTH-1:0] pixelValue,
  input  logic [PIXEL_WIDTH-1:0] pixelThreshold,
  input  logic                   dequeue,
  output logic                   readyForInputs,
  output logic                   outputsReady,
  output logic [INDEX_WIDTH-1:0] indexOut,
  output logic                   queueEmpty,
  output logic [INDEX_WIDTH:0]   activeCount
);

  typedef enum logic [1:0] {
    S_FREE     = 2'd0,
    S_FILLING  = 2'd1,
    S_FULL     = 2'd2,
    S_DRAINING = 2'd3
  } bank_state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(INPUT_LAYER_NODES - 1);

  bank_state_t            state_q  [2];
  bank_state_t            state_d  [2];
  logic [INDEX_WIDTH:0]   wr_ptr_q [2];
  logic [INDEX_WIDTH:0]   wr_ptr_d [2];
  logic [INDEX_WIDTH:0]   rd_ptr_q [2];
  logic [INDEX_WIDTH:0]   rd_ptr_d [2];
  logic [INDEX_WIDTH-1:0] mem_q    [2][INPUT_LAYER_NODES];

  logic [INDEX_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                   fill_sel_q, fill_sel_d;
  logic                   drain_sel_q, drain_sel_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic                   accept;
  logic                   active;
  logic                   last_pixel;
  logic                   head_valid;
  logic                   pop;
  logic                   release_bank;
  logic [INDEX_WIDTH-1:0] head;

  // The write pointer of a bank doubles as its active-index count.
  always_comb begin
    readyForInputs = (state_q[fill_sel_q] == S_FREE) || (state_q[fill_sel_q] == S_FILLING);
    outputsReady   = (state_q[drain_sel_q] == S_DRAINING);
    queueEmpty     = !outputsReady || (rd_ptr_q[drain_sel_q] == wr_ptr_q[drain_sel_q]);
    head           = mem_q[drain_sel_q][rd_ptr_q[drain_sel_q][INDEX_WIDTH-1:0]];
    head_valid     = outputsReady && !queueEmpty;
    indexOut       = head_valid ? head : index_q;
    activeCount    = outputsReady ? wr_ptr_q[drain_sel_q] : '0;
    accept         = inputsInbound && readyForInputs;
    active         = pixelValue > pixelThreshold;
    last_pixel     = (pix_cnt_q == LAST_IDX);
    pop            = dequeue && head_valid;
    release_bank   = dequeue && outputsReady && queueEmpty;
  end

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    index_d     = head_valid ? head : index_q;

    if (accept) begin
      pix_cnt_d = last_pixel ? '0 : pix_cnt_q + INDEX_WIDTH'(1);
      if (last_pixel) begin
        fill_sel_d = ~fill_sel_q;
      end
    end
    if (release_bank) begin
      drain_sel_d = ~drain_sel_q;
    end

    for (int b = 0; b < 2; b++) begin
      state_d[b]  = state_q[b];
      wr_ptr_d[b] = wr_ptr_q[b];
      rd_ptr_d[b] = rd_ptr_q[b];

      if (accept && (fill_sel_q == 1'(b)) && active) begin
        wr_ptr_d[b] = wr_ptr_q[b] + (INDEX_WIDTH + 1)'(1);
      end
      if (pop && (drain_sel_q == 1'(b))) begin
        rd_ptr_d[b] = rd_ptr_q[b] + (INDEX_WIDTH + 1)'(1);
      end

      case (state_q[b])
        S_FREE: begin
          if (accept && (fill_sel_q == 1'(b))) begin
            state_d[b] = last_pixel ? S_FULL : S_FILLING;
          end
        end
        S_FILLING: begin
          if (accept && (fill_sel_q == 1'(b)) && last_pixel) begin
            state_d[b] = S_FULL;
          end
        end
        // Drain order follows fill order, so only the selected bank can ever be draining.
        S_FULL: begin
          if (drain_sel_q == 1'(b)) begin
            state_d[b] = S_DRAINING;
          end
        end
        S_DRAINING: begin
          if (release_bank && (drain_sel_q == 1'(b))) begin
            state_d[b]  = S_FREE;
            wr_ptr_d[b] = '0;
            rd_ptr_d[b] = '0;
          end
        end
        default: state_d[b] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b]  <= S_FREE;
        wr_ptr_q[b] <= '0;
        rd_ptr_q[b] <= '0;
      end
      pix_cnt_q   <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      index_q     <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b]  <= state_d[b];
        wr_ptr_q[b] <= wr_ptr_d[b];
        rd_ptr_q[b] <= rd_ptr_d[b];
      end
      pix_cnt_q   <= pix_cnt_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      index_q     <= index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && active) begin
      mem_q[fill_sel_q][wr_ptr_q[fill_sel_q][INDEX_WIDTH-1:0]] <= pix_cnt_q;
    end
  end

endmodule
`default_nettype wire
